hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed two-source forward/load-stall hazard logic of the 5-stage core.
- Keeps one countdown per architectural register (integer plus FP file, 6-bit addresses) for the number of pipeline advances until that register's pending result reaches the register file.
- Each cycle, for the instruction in decode, it produces per-source forwarding selects and a single stall covering RAW, WAW-ordering and write-back-port hazards.
- Sits between decode and the stall/flush control in the CPU top and supports variable-latency (FPU, load) operations.

---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one countdown per architectural register until its
// pending result reaches the register file. Drives forwarding selects and a decode stall.
module hazard_scoreboard #(
    parameter int unsigned NREG      = 64,
    parameter int unsigned NSRC      = 2,
    parameter int unsigned MAX_LAT   = 7,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned ZERO_REG  = 1,
    localparam int unsigned RW = $clog2(NREG),
    localparam int unsigned LW = $clog2(MAX_LAT + 1),
    localparam int unsigned PW = $clog2(NREG + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               advance,
    input  logic               flush,
    input  logic               iss_valid,
    input  logic               iss_regwrite,
    input  logic [RW-1:0]      iss_rd,
    input  logic [LW-1:0]      iss_lat,
    input  logic [NSRC*RW-1:0] iss_rs,
    input  logic [NSRC-1:0]    iss_rs_used,
    output logic [NSRC*LW-1:0] fwd_sel,
    output logic               stall,
    output logic [PW-1:0]      pending_cnt,
    output logic               lat_err
);

    localparam logic [LW:0]   MAX_LAT_W = (LW + 1)'(MAX_LAT);
    localparam logic [LW-1:0] FWD_W     = LW'(FWD_DEPTH);

    logic [LW-1:0] cnt_q [NREG];
    logic [LW-1:0] cnt_d [NREG];
    logic [PW-1:0] pending_q;
    logic [PW-1:0] pending_d;
    logic          lat_err_q;
    logic          lat_err_d;

    logic [NSRC-1:0] raw_hz;
    logic            waw_hz;
    logic            wb_hz;
    logic            rd_trk;
    logic            lat_ok;
    logic            lat_bad;
    logic            issue;
    logic [PW-1:0]   retire;

    function automatic logic is_tracked(input logic [RW-1:0] r);
        return (ZERO_REG == 0) || (r != '0);
    endfunction

    // Per-source forwarding select or RAW hazard from the pre-issue counters
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [RW-1:0] rs;
        logic [LW-1:0] c;
        logic          live;

        assign rs   = iss_rs[gi*RW +: RW];
        assign c    = cnt_q[rs];
        assign live = iss_rs_used[gi] && is_tracked(rs) && (c != '0);

        assign fwd_sel[gi*LW +: LW] = (live && (c <= FWD_W)) ? c : '0;
        assign raw_hz[gi]           = live && (c > FWD_W);
    end

    // A completion already scheduled for the same advance would collide on the single write port
    always_comb begin
        wb_hz = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if ((cnt_q[r] != '0) && (cnt_q[r] == iss_lat)) begin
                wb_hz = 1'b1;
            end
        end
        wb_hz = wb_hz && iss_regwrite;
    end

    assign rd_trk  = is_tracked(iss_rd);
    assign waw_hz  = iss_regwrite && rd_trk && (cnt_q[iss_rd] > iss_lat);
    assign stall   = iss_valid && ((|raw_hz) || waw_hz || wb_hz);
    assign lat_ok  = (iss_lat != '0) && ({1'b0, iss_lat} <= MAX_LAT_W);
    assign lat_bad = iss_valid && iss_regwrite && advance && !flush && !lat_ok;
    assign issue   = iss_valid && iss_regwrite && advance && !stall && !flush
                     && rd_trk && lat_ok;

    // Counter next state: decrement on advance, issue overrides its own rd
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (advance) begin
            for (int r = 0; r < NREG; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LW'(1);
                end
            end
        end
        if (issue) begin
            cnt_d[iss_rd] = iss_lat;
        end
        lat_err_d = lat_err_q || lat_bad;
    end

    // Pending count: retirements are counters reaching zero that are not re-armed this cycle
    always_comb begin
        retire = '0;
        for (int r = 0; r < NREG; r++) begin
            if (advance && (cnt_q[r] == LW'(1)) && !(issue && (iss_rd == RW'(r)))) begin
                retire = retire + PW'(1);
            end
        end
        pending_d = pending_q - retire
                    + ((issue && (cnt_q[iss_rd] == '0)) ? PW'(1) : PW'(0));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            pending_q <= '0;
            lat_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_q <= pending_d;
            lat_err_q <= lat_err_d;
        end
    end

    assign pending_cnt = pending_q;
    assign lat_err     = lat_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, freeze, WAW/port,
// flush, zero register, mid-flight reset and latency error.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rstn;
    logic        advance;
    logic        flush;
    logic        iss_valid;
    logic        iss_regwrite;
    logic [5:0]  iss_rd;
    logic [2:0]  iss_lat;
    logic [11:0] iss_rs;
    logic [1:0]  iss_rs_used;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic [6:0]  pending_cnt;
    logic        lat_err;

    int n_vec;
    int n_err;

    hazard_scoreboard dut (
        .clk          (clk),
        .rstn         (rstn),
        .advance      (advance),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_regwrite (iss_regwrite),
        .iss_rd       (iss_rd),
        .iss_lat      (iss_lat),
        .iss_rs       (iss_rs),
        .iss_rs_used  (iss_rs_used),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .pending_cnt  (pending_cnt),
        .lat_err      (lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [5:0] rd,
                         input logic [2:0] lat, input logic [5:0] rs0, input logic [5:0] rs1,
                         input logic [1:0] used, input logic adv, input logic fl);
        iss_valid    = v;
        iss_regwrite = w;
        iss_rd       = rd;
        iss_lat      = lat;
        iss_rs       = {rs1, rs0};
        iss_rs_used  = used;
        advance      = adv;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 3'd0, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 3'd0, 6'd0, 6'd0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_lat_err", 32'(lat_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd", 32'(fwd_sel), 32'd0);

        // Back-to-back ALU, own rd as a source causes no self-hazard
        drive(1'b1, 1'b1, 6'd5, 3'd1, 6'd5, 6'd0, 2'b01, 1'b1, 1'b0);
        check("alu_self_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd5, 6'd0, 2'b01, 1'b1, 1'b0);
        check("alu_fwd1", 32'(fwd_sel), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_pending1", 32'(pending_cnt), 32'd1);
        tick();
        check("alu_fwd0", 32'(fwd_sel), 32'd0);
        check("alu_pending0", 32'(pending_cnt), 32'd0);

        // Load-use through source slot 1
        drive(1'b1, 1'b1, 6'd7, 3'd3, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd0, 6'd7, 2'b10, 1'b1, 1'b0);
        check("ld_stall", 32'(stall), 32'd1);
        check("ld_fwd_stall", 32'(fwd_sel), 32'd0);
        tick();
        check("ld_fwd2", 32'(fwd_sel), 32'd16);
        check("ld_stall_gone", 32'(stall), 32'd0);
        tick();
        check("ld_fwd1", 32'(fwd_sel), 32'd8);
        tick();
        check("ld_fwd0", 32'(fwd_sel), 32'd0);

        // Frozen pipeline: cnt9 = 2 (forwardable), cnt10 = 3 (stalling)
        drive(1'b1, 1'b1, 6'd10, 3'd4, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 6'd9, 3'd2, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        check("frz_issue_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd9, 6'd10, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("frz_fwd", 32'(fwd_sel), 32'd2);
            check("frz_stall", 32'(stall), 32'd1);
            tick();
        end
        check("frz_pending", 32'(pending_cnt), 32'd2);
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd9, 6'd10, 2'b11, 1'b1, 1'b0);
        check("thaw_fwd", 32'(fwd_sel), 32'd2);
        check("thaw_stall", 32'(stall), 32'd1);
        tick();
        check("thaw_fwd_a", 32'(fwd_sel), 32'd17);
        check("thaw_stall_a", 32'(stall), 32'd0);
        tick();
        check("thaw_fwd_b", 32'(fwd_sel), 32'd8);
        tick();
        check("thaw_pending", 32'(pending_cnt), 32'd0);

        // Write-back port and WAW against cnt40
        drive(1'b1, 1'b1, 6'd40, 3'd6, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b1, 6'd3, 3'd5, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        check("wb_port_stall", 32'(stall), 32'd1);
        drive(1'b1, 1'b1, 6'd3, 3'd4, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        check("wb_port_free", 32'(stall), 32'd0);
        drive(1'b1, 1'b1, 6'd40, 3'd6, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        check("waw_later_ok", 32'(stall), 32'd0);
        drive(1'b1, 1'b1, 6'd40, 3'd1, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("waw_stall", 32'(stall), 32'd1);
            tick();
        end
        idle();
        tick();
        check("waw_pending", 32'(pending_cnt), 32'd0);

        // Flush drops the decode issue while older entries keep counting
        drive(1'b1, 1'b1, 6'd20, 3'd3, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 6'd12, 3'd2, 6'd0, 6'd0, 2'b00, 1'b1, 1'b1);
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd12, 6'd20, 2'b11, 1'b1, 1'b0);
        check("flush_fwd", 32'(fwd_sel), 32'd16);
        check("flush_pending", 32'(pending_cnt), 32'd1);
        // Register 0 is never tracked
        drive(1'b1, 1'b1, 6'd0, 3'd1, 6'd0, 6'd0, 2'b01, 1'b1, 1'b0);
        check("zero_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd0, 6'd20, 2'b11, 1'b1, 1'b0);
        check("zero_fwd", 32'(fwd_sel), 32'd8);
        check("zero_pending", 32'(pending_cnt), 32'd1);
        tick();
        check("zero_lat_err", 32'(lat_err), 32'd0);

        // Four in flight, then reset mid-operation
        drive(1'b1, 1'b1, 6'd1, 3'd7, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 6'd2, 3'd5, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 6'd3, 3'd3, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 6'd4, 3'd7, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd3, 6'd4, 2'b11, 1'b0, 1'b0);
        check("mid_pending4", 32'(pending_cnt), 32'd4);
        check("mid_fwd", 32'(fwd_sel), 32'd2);
        check("mid_stall", 32'(stall), 32'd1);
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd3, 6'd4, 2'b01, 1'b0, 1'b0);
        check("unused_src_stall", 32'(stall), 32'd0);
        drive(1'b1, 1'b0, 6'd0, 3'd1, 6'd3, 6'd4, 2'b11, 1'b0, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        check("post_rst_pending", 32'(pending_cnt), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_fwd", 32'(fwd_sel), 32'd0);
        check("post_rst_lat_err", 32'(lat_err), 32'd0);

        // Illegal latency: ignored under flush or freeze, sticky otherwise
        drive(1'b1, 1'b1, 6'd8, 3'd0, 6'd0, 6'd0, 2'b00, 1'b1, 1'b1);
        tick();
        check("laterr_flush", 32'(lat_err), 32'd0);
        drive(1'b1, 1'b1, 6'd8, 3'd0, 6'd0, 6'd0, 2'b00, 1'b0, 1'b0);
        tick();
        check("laterr_frozen", 32'(lat_err), 32'd0);
        drive(1'b1, 1'b1, 6'd8, 3'd0, 6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
        check("laterr_stall", 32'(stall), 32'd0);
        tick();
        check("laterr_set", 32'(lat_err), 32'd1);
        check("laterr_untracked", 32'(pending_cnt), 32'd0);
        idle();
        tick();
        tick();
        tick();
        check("laterr_sticky", 32'(lat_err), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        check("laterr_cleared", 32'(lat_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
